// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline types: control bundle, ALU op encoding, bubble constant.
package pipe_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_LUI  = 4'd10,
        ALU_PASS = 4'd11
    } alu_op_e;

    typedef struct packed {
        logic    regWrite;
        logic    memRead;
        logic    memWrite;
        logic    memToReg;
        logic    aluSrc;
        logic    branch;
        logic    jump;
        alu_op_e aluOp;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = ctrl_t'(11'd0);

endpackage

// File: rtl/id_ex_stage_if.sv
// ID->EX bus: decoded instruction in, registered copy and stall out.
interface id_ex_stage_if
    import pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic            id_valid_i;
    logic [XLEN-1:0] id_pc_i;
    logic [XLEN-1:0] id_rs1_data_i;
    logic [XLEN-1:0] id_rs2_data_i;
    logic [XLEN-1:0] id_imm_i;
    logic [4:0]      id_rs1_i;
    logic [4:0]      id_rs2_i;
    logic [4:0]      id_rd_i;
    ctrl_t           id_ctrl_i;

    logic            ex_valid_o;
    logic [XLEN-1:0] ex_pc_o;
    logic [XLEN-1:0] ex_rs1_data_o;
    logic [XLEN-1:0] ex_rs2_data_o;
    logic [XLEN-1:0] ex_imm_o;
    logic [4:0]      ex_rs1_o;
    logic [4:0]      ex_rs2_o;
    logic [4:0]      ex_rd_o;
    ctrl_t           ex_ctrl_o;
    logic            load_use_stall_o;

    modport slave (
        input  id_valid_i, id_pc_i, id_rs1_data_i, id_rs2_data_i,
        input  id_imm_i, id_rs1_i, id_rs2_i, id_rd_i, id_ctrl_i,
        output ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o,
        output ex_imm_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_ctrl_o,
        output load_use_stall_o
    );

    modport master (
        output id_valid_i, id_pc_i, id_rs1_data_i, id_rs2_data_i,
        output id_imm_i, id_rs1_i, id_rs2_i, id_rd_i, id_ctrl_i,
        input  ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o,
        input  ex_imm_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_ctrl_o,
        input  load_use_stall_o
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard: a load in EX whose rd feeds a source of the ID instruction.
module hazard_detect (
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    output logic       load_use_o
);

    always_comb begin
        load_use_o = ex_valid_i && ex_mem_read_i && (ex_rd_i != 5'd0) &&
                     ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and hold.
// Define ID_EX_PERF_EN to add saturating stall/flush event counters.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         hold_i,
`ifdef ID_EX_PERF_EN
    output logic [31:0]  stall_cnt_o,
    output logic [31:0]  flush_cnt_o,
`endif
    id_ex_stage_if.slave bus
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rs1d_q, rs1d_d;
    logic [XLEN-1:0] rs2d_q, rs2d_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [4:0]      rs2_q, rs2_d;
    logic [4:0]      rd_q, rd_d;
    ctrl_t           ctrl_q, ctrl_d;
    logic            load_use;
    logic            stall;
    logic            bubble;

    hazard_detect u_hazard (
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (ctrl_q.memRead),
        .ex_rd_i       (rd_q),
        .id_rs1_i      (bus.id_rs1_i),
        .id_rs2_i      (bus.id_rs2_i),
        .load_use_o    (load_use)
    );

    assign stall  = load_use && bus.id_valid_i && !flush_i && !hold_i;
    assign bubble = flush_i || (!hold_i && (stall || !bus.id_valid_i));

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        rs1d_d  = rs1d_q;
        rs2d_d  = rs2d_q;
        imm_d   = imm_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        // A bubble only kills identity and control; data lanes keep their value.
        if (bubble) begin
            valid_d = 1'b0;
            ctrl_d  = BUBBLE_CTRL;
            rs1_d   = 5'd0;
            rs2_d   = 5'd0;
            rd_d    = 5'd0;
        end else if (!hold_i) begin
            valid_d = 1'b1;
            pc_d    = bus.id_pc_i;
            rs1d_d  = bus.id_rs1_data_i;
            rs2d_d  = bus.id_rs2_data_i;
            imm_d   = bus.id_imm_i;
            rs1_d   = bus.id_rs1_i;
            rs2_d   = bus.id_rs2_i;
            rd_d    = bus.id_rd_i;
            ctrl_d  = bus.id_ctrl_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rs1d_q  <= '0;
            rs2d_q  <= '0;
            imm_q   <= '0;
            rs1_q   <= 5'd0;
            rs2_q   <= 5'd0;
            rd_q    <= 5'd0;
            ctrl_q  <= BUBBLE_CTRL;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rs1d_q  <= rs1d_d;
            rs2d_q  <= rs2d_d;
            imm_q   <= imm_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.ex_valid_o       = valid_q;
    assign bus.ex_pc_o          = pc_q;
    assign bus.ex_rs1_data_o    = rs1d_q;
    assign bus.ex_rs2_data_o    = rs2d_q;
    assign bus.ex_imm_o         = imm_q;
    assign bus.ex_rs1_o         = rs1_q;
    assign bus.ex_rs2_o         = rs2_q;
    assign bus.ex_rd_o          = rd_q;
    assign bus.ex_ctrl_o        = ctrl_q;
    assign bus.load_use_stall_o = stall;

`ifdef ID_EX_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush_i && !hold_i && flush_cnt_q != 32'hFFFF_FFFF) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios, then random traffic.
module tb_id_ex_stage;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic flush_i;
    logic hold_i;
`ifdef ID_EX_PERF_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;
    logic [31:0] e_scnt;
    logic [31:0] e_fcnt;
`endif

    id_ex_stage_if #(.XLEN(32)) bus ();

    id_ex_stage #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .hold_i      (hold_i),
`ifdef ID_EX_PERF_EN
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Expected contents of the EX side of the stage
    logic        e_valid;
    logic [31:0] e_pc, e_rs1d, e_rs2d, e_imm;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    ctrl_t       e_ctrl;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input ctrl_t c);
        bus.id_valid_i    = v;
        bus.id_pc_i       = pc;
        bus.id_rs1_data_i = $urandom;
        bus.id_rs2_data_i = $urandom;
        bus.id_imm_i      = $urandom;
        bus.id_rs1_i      = rs1;
        bus.id_rs2_i      = rs2;
        bus.id_rd_i       = rd;
        bus.id_ctrl_i     = c;
    endtask

    function automatic ctrl_t mk_ctrl(input logic mr, input logic rw);
        ctrl_t c;
        c = ctrl_t'(11'd0);
        c.memRead  = mr;
        c.memToReg = mr;
        c.regWrite = rw;
        return c;
    endfunction

    task automatic model_bubble();
        e_valid = 1'b0;
        e_ctrl  = ctrl_t'(11'd0);
        e_rs1   = 5'd0;
        e_rs2   = 5'd0;
        e_rd    = 5'd0;
    endtask

    task automatic model_reset();
        model_bubble();
        e_pc   = '0;
        e_rs1d = '0;
        e_rs2d = '0;
        e_imm  = '0;
`ifdef ID_EX_PERF_EN
        e_scnt = '0;
        e_fcnt = '0;
`endif
    endtask

    // One clock: check the stall request, take the edge, update model, check EX.
    task automatic cycle();
        logic hazard;
        logic exp_st;
        hazard = e_valid && e_ctrl.memRead && e_rd != 5'd0 &&
                 (e_rd == bus.id_rs1_i || e_rd == bus.id_rs2_i);
        exp_st = hazard && bus.id_valid_i && !flush_i && !hold_i;
        #1;
        chk("load_use_stall", 64'(bus.load_use_stall_o), 64'(exp_st));
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (flush_i) begin
            model_bubble();
`ifdef ID_EX_PERF_EN
            if (!hold_i && e_fcnt != 32'hFFFF_FFFF) e_fcnt = e_fcnt + 1;
`endif
        end else if (hold_i) begin
            e_valid = e_valid;
        end else if (exp_st || !bus.id_valid_i) begin
            model_bubble();
`ifdef ID_EX_PERF_EN
            if (exp_st && e_scnt != 32'hFFFF_FFFF) e_scnt = e_scnt + 1;
`endif
        end else begin
            e_valid = 1'b1;
            e_pc    = bus.id_pc_i;
            e_rs1d  = bus.id_rs1_data_i;
            e_rs2d  = bus.id_rs2_data_i;
            e_imm   = bus.id_imm_i;
            e_rs1   = bus.id_rs1_i;
            e_rs2   = bus.id_rs2_i;
            e_rd    = bus.id_rd_i;
            e_ctrl  = bus.id_ctrl_i;
        end
        #1;
        chk("ex_valid", 64'(bus.ex_valid_o), 64'(e_valid));
        chk("ex_pc", 64'(bus.ex_pc_o), 64'(e_pc));
        chk("ex_rs1_data", 64'(bus.ex_rs1_data_o), 64'(e_rs1d));
        chk("ex_rs2_data", 64'(bus.ex_rs2_data_o), 64'(e_rs2d));
        chk("ex_imm", 64'(bus.ex_imm_o), 64'(e_imm));
        chk("ex_rs1", 64'(bus.ex_rs1_o), 64'(e_rs1));
        chk("ex_rs2", 64'(bus.ex_rs2_o), 64'(e_rs2));
        chk("ex_rd", 64'(bus.ex_rd_o), 64'(e_rd));
        chk("ex_ctrl", 64'(bus.ex_ctrl_o), 64'(e_ctrl));
`ifdef ID_EX_PERF_EN
        chk("stall_cnt", 64'(stall_cnt_o), 64'(e_scnt));
        chk("flush_cnt", 64'(flush_cnt_o), 64'(e_fcnt));
`endif
    endtask

    initial begin
        logic [31:0] snap_pc;
        ctrl_t       snap_ctrl;

        rst_n   = 1'b0;
        flush_i = 1'b0;
        hold_i  = 1'b0;
        set_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, mk_ctrl(1'b1, 1'b1));
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cycle();
        chk("reset_valid", 64'(bus.ex_valid_o), 64'd0);
        rst_n = 1'b1;

        // lw x5 then dependent add x6,x5,x7
        set_id(1'b1, 32'h200, 5'd2, 5'd0, 5'd5, mk_ctrl(1'b1, 1'b1));
        cycle();
        set_id(1'b1, 32'h204, 5'd5, 5'd7, 5'd6, mk_ctrl(1'b0, 1'b1));
        #1;
        chk("lw_add_stall", 64'(bus.load_use_stall_o), 64'd1);
        cycle();
        chk("lw_add_bubble_valid", 64'(bus.ex_valid_o), 64'd0);
        chk("lw_add_bubble_ctrl", 64'(bus.ex_ctrl_o), 64'd0);
        cycle();
        chk("lw_add_loaded_rs1", 64'(bus.ex_rs1_o), 64'd5);
        chk("lw_add_loaded_pc", 64'(bus.ex_pc_o), 64'h204);

        // lw x0: reading x0 never stalls
        set_id(1'b1, 32'h300, 5'd1, 5'd0, 5'd0, mk_ctrl(1'b1, 1'b1));
        cycle();
        set_id(1'b1, 32'h304, 5'd0, 5'd0, 5'd8, mk_ctrl(1'b0, 1'b1));
        cycle();
        chk("lw_x0_loaded", 64'(bus.ex_pc_o), 64'h304);

        // flush wins over hold
        set_id(1'b1, 32'h40, 5'd1, 5'd2, 5'd3, mk_ctrl(1'b0, 1'b1));
        flush_i = 1'b1;
        hold_i  = 1'b1;
        cycle();
        chk("flush_hold_valid", 64'(bus.ex_valid_o), 64'd0);
        chk("flush_pc_not_loaded", 64'(bus.ex_pc_o == 32'h40), 64'd0);
        flush_i = 1'b0;
        hold_i  = 1'b0;

        // hold 3 cycles with a load to x9 in EX and a dependent ID
        set_id(1'b1, 32'h500, 5'd1, 5'd2, 5'd9, mk_ctrl(1'b1, 1'b1));
        cycle();
        snap_pc   = bus.ex_pc_o;
        snap_ctrl = bus.ex_ctrl_o;
        set_id(1'b1, 32'h504, 5'd9, 5'd9, 5'd4, mk_ctrl(1'b0, 1'b1));
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("hold_pc", 64'(bus.ex_pc_o), 64'(snap_pc));
            chk("hold_rd", 64'(bus.ex_rd_o), 64'd9);
            chk("hold_ctrl", 64'(bus.ex_ctrl_o), 64'(snap_ctrl));
        end
        hold_i = 1'b0;

        // reset during an active stall
        #1;
        chk("pre_reset_stall", 64'(bus.load_use_stall_o), 64'd1);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("rst_stall_valid", 64'(bus.ex_valid_o), 64'd0);
        chk("rst_stall_ctrl", 64'(bus.ex_ctrl_o), 64'd0);
        chk("rst_stall_deassert", 64'(bus.load_use_stall_o), 64'd0);

`ifdef ID_EX_PERF_EN
        chk("rst_stall_cnt", 64'(stall_cnt_o), 64'd0);
        chk("rst_flush_cnt", 64'(flush_cnt_o), 64'd0);
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        e_scnt = 32'hFFFF_FFFE;
        for (int k = 0; k < 2; k++) begin
            set_id(1'b1, 32'h600, 5'd1, 5'd2, 5'd5, mk_ctrl(1'b1, 1'b1));
            cycle();
            set_id(1'b1, 32'h604, 5'd5, 5'd3, 5'd6, mk_ctrl(1'b0, 1'b1));
            cycle();
            cycle();
        end
        chk("stall_cnt_sat", 64'(stall_cnt_o), 64'hFFFF_FFFF);
`endif

        // random traffic with small register index range to provoke hazards
        for (int n = 0; n < 400; n++) begin
            bus.id_valid_i    = ($urandom_range(0, 7) != 0);
            bus.id_pc_i       = $urandom;
            bus.id_rs1_data_i = $urandom;
            bus.id_rs2_data_i = $urandom;
            bus.id_imm_i      = $urandom;
            bus.id_rs1_i      = 5'($urandom_range(0, 3));
            bus.id_rs2_i      = 5'($urandom_range(0, 3));
            bus.id_rd_i       = 5'($urandom_range(0, 3));
            bus.id_ctrl_i     = ctrl_t'(11'($urandom));
            flush_i           = ($urandom_range(0, 9) == 0);
            hold_i            = ($urandom_range(0, 5) == 0);
            rst_n             = ($urandom_range(0, 49) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have id_valid_i  input  1  decode stage holds a valid instruction.
REQ-005 SHALL have id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i  input  XLEN each  decoded operands.
REQ-006 SHALL have id_rs1_i, id_rs2_i, id_rd_i  input  5 each  register indices.
REQ-007 SHALL have id_ctrl_i  input  ctrl_t  regWrite, memRead, memWrite, memToReg, aluSrc, branch, jump, aluOp[3:0].
REQ-008 SHALL have flush_i  input  1  kill the decode instruction, e.g. taken branch resolved in EX.
REQ-009 SHALL have hold_i  input  1  external back-pressure freezing the stage.
REQ-010 SHALL have ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_ctrl_o  output  registered copies of the inputs.
REQ-011 SHALL have load_use_stall_o  output  1  combinational; tells PC and IF/ID to hold.

Function
REQ-012 SHALL register all inputs on each rising clk edge, one-cycle latency, when no hold, flush or bubble applies.
REQ-013 SHALL detect load-use when ex_ctrl_o.memRead=1, ex_valid_o=1, ex_rd_o!=0 and ex_rd_o equals id_rs1_i or id_rs2_i.
REQ-014 SHALL drive load_use_stall_o = load-use AND id_valid_i AND NOT flush_i AND NOT hold_i.
REQ-015 SHALL insert a bubble when load_use_stall_o=1.
REQ-016 A bubble SHALL set ex_valid_o=0, all ex_ctrl_o bits=0, and ex_rd_o, ex_rs1_o, ex_rs2_o=0, so downstream forwarding never matches.
REQ-017 SHALL load a bubble when flush_i=1, regardless of hold_i.
REQ-018 SHALL retain all registers when hold_i=1 and flush_i=0; load-use SHALL NOT insert a bubble during hold.
REQ-019 Priority per edge SHALL be: reset > flush > hold > load-use bubble > load.
REQ-020 When id_valid_i=0, SHALL load a bubble (no load-use stall).
REQ-021 A load-use stall SHALL last exactly one cycle; the next edge, with the bubble in EX, SHALL load the held instruction.

Reset
REQ-022 While rst_n=0 at an edge, all registers SHALL become the bubble value and ex_pc_o, data and imm outputs SHALL become 0.
REQ-023 Reset asserted mid-stall SHALL clear the stall; load_use_stall_o SHALL be 0 in the first cycle after reset.

Configuration
REQ-024 With ID_EX_PERF_EN defined, SHALL add stall_cnt_o[31:0], counting load-use bubbles, and flush_cnt_o[31:0], counting flush edges; both saturate at 0xFFFFFFFF, reset to 0, and hold during hold_i.
REQ-025 Without ID_EX_PERF_EN, these ports and counters SHALL NOT exist; all other behaviour is identical.

Structure
REQ-026 Package pipe_pkg SHALL hold ctrl_t (packed struct), the aluOp enum, XLEN default and the BUBBLE_CTRL constant.
REQ-027 Load-use comparison SHALL be the sub-module hazard_detect (purely combinational); id_ex_stage instantiates it once.

Verification
REQ-028 lw x5 in EX (memRead=1, rd=5), add x6,x5,x7 in ID -> load_use_stall_o=1, next edge ex_valid_o=0/ctrl=0, following edge add loaded with rs1=5.
REQ-029 lw x0 in EX, ID reads x0 -> load_use_stall_o=0, instruction loads normally.
REQ-030 flush_i=1 and hold_i=1 together with valid ID instruction pc=0x40 -> next edge bubble, ex_pc_o=0x40 not loaded.
REQ-031 hold_i=1 for 3 cycles with ex_rd_o=9 -> outputs unchanged 3 cycles, load_use_stall_o=0 throughout.
REQ-032 rst_n=0 for one edge during an active stall -> all ctrl 0, ex_valid_o=0, stall deasserted; with ID_EX_PERF_EN, counters=0.
REQ-033 With ID_EX_PERF_EN, force stall_cnt_o=0xFFFFFFFE, apply two load-use stalls -> counter saturates at 0xFFFFFFFF.
